// File: rtl/tas_pkg.sv
// Shared types and constants for the temperature averaging serial front end.
package tas_pkg;

  localparam logic [7:0] HDR_TEMP0 = 8'hA5;
  localparam logic [7:0] HDR_TEMP1 = 8'hC3;
  localparam int PKT_LEN_DEF = 5;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
    logic       temp;
  } rx_word_t;

  function automatic logic is_temp_hdr(
    input logic [7:0] b
  );
    return (b == HDR_TEMP0) || (b == HDR_TEMP1);
  endfunction

endpackage

// File: rtl/tas_rx_fifo.sv
// Synchronous FIFO of tagged rx words; head is read straight from
// the storage registers and forced to zero while empty.
module tas_rx_fifo
  import tas_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  rx_word_t wdata_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output rx_word_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  rx_word_t    mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        wr_en;
  logic        rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot a full-FIFO push lands in, on the same edge.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + PTR_ONE;
      if (rd_en) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tas_rx_framer.sv
// Serial byte framer with packet tagging and output FIFO.
// Define TAS_RX_HDR_FILTER_EN to drop bytes of non-temperature packets.
module tas_rx_framer
  import tas_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_LEN    = PKT_LEN_DEF
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       serial_data,
  input  logic       data_ena,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_idx,
  output logic       out_temp,
  output logic       short_err,
  output logic       ovf
);

  localparam logic [2:0] IDX_LAST = 3'(PKT_LEN - 1);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [2:0] pkt_idx_q, pkt_idx_d;
  logic       temp_q, temp_d;
  logic       wvld_q, wvld_d;
  rx_word_t   word_q, word_d;
  logic       short_q, short_d;
  logic       ovf_q, ovf_d;

  logic [7:0] byte_w;
  logic       flag_w;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  rx_word_t   head;

  // Bits arrive LSB first: shift right so bit 0 ends at sh_q[0].
  assign byte_w = {serial_data, sh_q};
  assign flag_w = (pkt_idx_q == '0) ? is_temp_hdr(byte_w) : temp_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    pkt_idx_d = pkt_idx_q;
    temp_d    = temp_q;
    wvld_d    = 1'b0;
    word_d    = word_q;
    short_d   = 1'b0;
    if (data_ena) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      sh_d      = {serial_data, sh_q[6:1]};
      if (bit_cnt_q == 3'd7) begin
        wvld_d = 1'b1;
        word_d = '{data: byte_w,
                   idx:  pkt_idx_q,
                   temp: flag_w};
        temp_d = flag_w;
        pkt_idx_d = (pkt_idx_q == IDX_LAST) ?
                    3'd0 : pkt_idx_q + 3'd1;
      end
    end else if (bit_cnt_q != '0) begin
      bit_cnt_d = '0;
      short_d   = 1'b1;
    end
  end

`ifdef TAS_RX_HDR_FILTER_EN
  assign push = wvld_q && word_q.temp;
`else
  assign push = wvld_q;
`endif

  assign pop   = out_valid && out_ready;
  assign ovf_d = ovf_q | (push & full & ~pop);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
      sh_q      <= '0;
      pkt_idx_q <= '0;
      temp_q    <= 1'b0;
      wvld_q    <= 1'b0;
      word_q    <= '0;
      short_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      pkt_idx_q <= pkt_idx_d;
      temp_q    <= temp_d;
      wvld_q    <= wvld_d;
      word_q    <= word_d;
      short_q   <= short_d;
      ovf_q     <= ovf_d;
    end
  end

  tas_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_50),
    .rst_ni (reset_n),
    .push_i (push),
    .wdata_i(word_q),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );

  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_idx   = head.idx;
  assign out_temp  = head.temp;
  assign short_err = short_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_tas_rx_framer.sv
// Randomised bench for tas_rx_framer against a queue-based packet model.
module tb_tas_rx_framer;

  localparam int DEPTH = 8;
  localparam int PKT   = 5;
`ifdef TAS_RX_HDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk_50 = 1'b0;
  logic       reset_n;
  logic       serial_data;
  logic       data_ena;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_temp;
  logic       short_err;
  logic       ovf;

  tas_rx_framer #(
    .FIFO_DEPTH(DEPTH),
    .PKT_LEN   (PKT)
  ) dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .serial_data(serial_data),
    .data_ena   (data_ena),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_temp   (out_temp),
    .short_err  (short_err),
    .ovf        (ovf)
  );

  always #10 clk_50 = ~clk_50;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: bytes, packet position and a FIFO queue.
  typedef struct {
    logic [7:0] d;
    int         idx;
    logic       t;
  } mw_t;

  mw_t  mq[$];
  mw_t  mlog[$];
  mw_t  pend;
  bit   pend_v = 0;
  int   bcnt = 0;
  logic [7:0] bacc = '0;
  int   ppos = 0;
  bit   pflag = 0;
  bit   short_m = 0;
  bit   ovf_m = 0;
  int   sh_cnt = 0;
  bit   m_pop;
  bit   m_full;

  always @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      pend_v  = 0;
      bcnt    = 0;
      ppos    = 0;
      pflag   = 0;
      short_m = 0;
      ovf_m   = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_full = (mq.size() == DEPTH);
      if (m_pop) begin
        mlog.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (pend_v && (!FILT || pend.t)) begin
        if (m_full && !m_pop) ovf_m = 1;
        else mq.push_back(pend);
      end
      pend_v  = 0;
      short_m = 0;
      if (data_ena) begin
        bacc[bcnt] = serial_data;
        bcnt++;
        if (bcnt == 8) begin
          if (ppos == 0)
            pflag = (bacc == 8'hA5) || (bacc == 8'hC3);
          pend   = '{bacc, ppos, pflag};
          pend_v = 1;
          ppos   = (ppos + 1) % PKT;
          bcnt   = 0;
        end
      end else if (bcnt != 0) begin
        short_m = 1;
        sh_cnt++;
        bcnt = 0;
      end
    end
  end

  always @(negedge clk_50) begin
    chk("valid", out_valid, mq.size() > 0);
    if (out_valid && mq.size() > 0) begin
      chk("data", out_data, mq[0].d);
      chk("idx",  out_idx,  mq[0].idx);
      chk("temp", out_temp, mq[0].t);
    end
    if (!reset_n) begin
      chk("rst_data", out_data, 0);
      chk("rst_idx",  out_idx,  0);
      chk("rst_temp", out_temp, 0);
    end
    chk("short_err", short_err, short_m);
    chk("ovf", ovf, ovf_m);
  end

  bit rand_rdy = 0;
  always @(posedge clk_50) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom);
  end

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic idle(input int n);
    data_ena = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_bits(input logic [7:0] b,
                           input int n,
                           input int gap);
    for (int i = 0; i < n; i++) begin
      serial_data = b[i];
      data_ena    = 1'b1;
      step();
    end
    idle(gap);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    send_bits(b, 8, gap);
  endtask

  task automatic chk_pkt(input string nm,
                         input int base,
                         input logic [7:0] exp_d [5],
                         input logic exp_t);
    chk({nm, "_cnt"}, mlog.size() - base, 5);
    if (mlog.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk({nm, "_d"}, mlog[base+i].d, exp_d[i]);
        chk({nm, "_i"}, mlog[base+i].idx, i);
        chk({nm, "_t"}, mlog[base+i].t, exp_t);
      end
    end
  endtask

  logic [7:0] t1 [5] = '{8'hA5, 8'h3A, 8'h55, 8'h43, 8'h3C};
  logic [7:0] t2 [5] = '{8'hA5, 8'h0A, 8'h14, 8'h1E, 8'h28};
  logic [7:0] t3 [5] = '{8'h83, 8'hA5, 8'hC3, 8'hA5, 8'hC3};
  logic [7:0] t3b[5] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] t4 [5] = '{8'hA5, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
  logic [7:0] t5 [10] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44,
                          8'hA5, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] t6 [5] = '{8'hA5, 8'h21, 8'h22, 8'h23, 8'h24};

  int base;
  int shb;
  int r;
  logic [7:0] rb;

  initial begin
    reset_n     = 1'b0;
    serial_data = 1'b0;
    data_ena    = 1'b0;
    out_ready   = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    out_ready = 1'b1;
    base = mlog.size();
    foreach (t1[i]) send_byte(t1[i], 4);
    idle(5);
    chk_pkt("t1", base, t1, 1'b1);

    out_ready = 1'b0;
    base = mlog.size();
    foreach (t2[i]) send_byte(t2[i], 1);
    idle(3);
    chk("t2_held", mq.size(), 5);
    out_ready = 1'b1;
    idle(10);
    chk_pkt("t2", base, t2, 1'b1);
    chk("t2_ovf", ovf_m, 0);

    base = mlog.size();
    foreach (t3[i]) send_byte(t3[i], 2);
    idle(4);
    if (FILT) chk("t3_cnt", mlog.size() - base, 0);
    else chk_pkt("t3", base, t3, 1'b0);
    base = mlog.size();
    foreach (t3b[i]) send_byte(t3b[i], 2);
    idle(4);
    chk_pkt("t3b", base, t3b, 1'b1);

    shb  = sh_cnt;
    base = mlog.size();
    send_bits(8'hFF, 5, 3);
    chk("t4_short", sh_cnt - shb, 1);
    chk("t4_noword", mlog.size() - base, 0);
    foreach (t4[i]) send_byte(t4[i], 2);
    idle(4);
    chk_pkt("t4", base, t4, 1'b1);

    out_ready = 1'b0;
    foreach (t5[i]) send_byte(t5[i], 1);
    idle(3);
    chk("t5_held", mq.size(), 8);
    chk("t5_ovf", ovf_m, 1);
    if (mq.size() == 8)
      for (int i = 0; i < 8; i++) chk("t5_d", mq[i].d, t5[i]);
    out_ready = 1'b1;
    idle(12);
    chk("t5_sticky", ovf_m, 1);

    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    reset_n = 1'b0;
    idle(2);
    chk("t6_ovf", ovf_m, 0);
    reset_n = 1'b1;
    step();
    base = mlog.size();
    foreach (t6[i]) send_byte(t6[i], 1);
    idle(4);
    chk_pkt("t6", base, t6, 1'b1);

    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      rb = 8'($urandom);
      if (r == 0) send_bits(rb, $urandom_range(1, 7), 1);
      else if (r < 4) send_byte(8'hA5, $urandom_range(0, 3));
      else if (r < 5) send_byte(8'hC3, $urandom_range(0, 3));
      else send_byte(rb, $urandom_range(0, 3));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(20);
    chk("rand_drain", mq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
